// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch / sequencing unit.
package instr_fetch_pkg;

    // Default widths: program counter, goto-table index, RUN-cycle counter.
    localparam int PC_W_DEF   = 10;
    localparam int LUT_AW_DEF = 5;
    localparam int CNT_W_DEF  = 16;

    // Program sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage : instr_fetch_pkg

// File: rtl/instr_fetch_goto_lut.sv
// Goto-target table: one synchronous write port, one combinational read port.
// A same-cycle write and read of one index returns the old entry.
module goto_lut #(
    parameter int AW = 5,
    parameter int DW = 10
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [2**AW];

    // Table storage: cleared by reset, written on the strobe.
    // NOTE: this array is deliberately reset (program-visible state must start at 0),
    // so it maps to flops rather than a RAM macro, which cannot be cleared in one cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < 2**AW; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule : goto_lut

// File: rtl/instr_fetch.sv
// Instruction fetch/sequencing unit: start/done handshake FSM, program
// counter with goto/skip/increment, sticky wrap flag and saturating RUN-cycle count.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int LUT_AW = LUT_AW_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              GotoEn,
    input  logic              Jump2En,
    input  logic              Ack,
    input  logic              Zero,
    input  logic [LUT_AW-1:0] Target_Idx,
    input  logic              Lut_WrEn,
    input  logic [LUT_AW-1:0] Lut_WrAddr,
    input  logic [PC_W-1:0]   Lut_WrData,
    output logic [PC_W-1:0]   PC,
    output logic              Running,
    output logic              Done,
    output logic              Wrapped,
    output logic [CNT_W-1:0]  Cycle_Count
);

    fetch_state_t     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             wrapped_q, wrapped_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [PC_W-1:0]  goto_target;
    logic             skip;
    logic [PC_W:0]    pc_sum;   // extra bit is the carry out of the increment

    goto_lut #(
        .AW (LUT_AW),
        .DW (PC_W)
    ) u_goto_lut (
        .clk_i     (Clk),
        .reset_i   (Reset),
        .wr_en_i   (Lut_WrEn),
        .wr_addr_i (Lut_WrAddr),
        .wr_data_i (Lut_WrData),
        .rd_addr_i (Target_Idx),
        .rd_data_o (goto_target)
    );

    // Sequential PC step: +2 when the skip condition holds, else +1.
    assign skip   = Jump2En & Zero;
    assign pc_sum = {1'b0, pc_q} + {{(PC_W-1){1'b0}}, skip, ~skip};

    // Next-state logic: Start overrides everything; in RUN, Ack > Goto > Jump2 > +1.
    // NOTE: every output of this block gets a default first so no path leaves it
    // unassigned, which is what keeps synthesis from inferring latches.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        wrapped_d = wrapped_q;
        cnt_d     = cnt_q;
        if (Start) begin
            state_d   = IDLE;
            pc_d      = '0;
            wrapped_d = 1'b0;
            cnt_d     = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    pc_d    = '0;
                    state_d = RUN;
                end
                RUN: begin
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (Ack) begin
                        state_d = HALT;
                    end else if (GotoEn) begin
                        pc_d = goto_target;
                    end else begin
                        pc_d = pc_sum[PC_W-1:0];
                        if (pc_sum[PC_W]) begin
                            wrapped_d = 1'b1;
                        end
                    end
                end
                HALT: begin
                    state_d = HALT;
                end
                default: begin
                    state_d = IDLE;
                    pc_d    = '0;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            wrapped_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            wrapped_q <= wrapped_d;
            cnt_q     <= cnt_d;
        end
    end

    assign PC          = pc_q;
    assign Running     = (state_q == RUN);
    assign Done        = (state_q == HALT);
    assign Wrapped     = wrapped_q;
    assign Cycle_Count = cnt_q;

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_instr_fetch;

    localparam int PC_W    = 10;
    localparam int LUT_AW  = 5;
    localparam int CNT_W   = 8;   // narrow counter so saturation is reachable
    localparam int PC_SPAN = 1 << PC_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int LUT_N   = 1 << LUT_AW;

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_HALT = 2;

    logic              Clk = 1'b0;
    logic              Reset, Start, GotoEn, Jump2En, Ack, Zero, Lut_WrEn;
    logic [LUT_AW-1:0] Target_Idx, Lut_WrAddr;
    logic [PC_W-1:0]   Lut_WrData;
    logic [PC_W-1:0]   PC;
    logic              Running, Done, Wrapped;
    logic [CNT_W-1:0]  Cycle_Count;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    // Behavioural model state.
    int m_state, m_pc, m_wrap, m_cnt, m_step;
    int m_lut [LUT_N];

    always #5 Clk = ~Clk;

    instr_fetch #(
        .PC_W   (PC_W),
        .LUT_AW (LUT_AW),
        .CNT_W  (CNT_W)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .GotoEn      (GotoEn),
        .Jump2En     (Jump2En),
        .Ack         (Ack),
        .Zero        (Zero),
        .Target_Idx  (Target_Idx),
        .Lut_WrEn    (Lut_WrEn),
        .Lut_WrAddr  (Lut_WrAddr),
        .Lut_WrData  (Lut_WrData),
        .PC          (PC),
        .Running     (Running),
        .Done        (Done),
        .Wrapped     (Wrapped),
        .Cycle_Count (Cycle_Count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: program behaviour expressed with plain integer arithmetic.
    always @(posedge Clk) begin
        if (Reset) begin
            m_state <= S_IDLE;
            m_pc    <= 0;
            m_wrap  <= 0;
            m_cnt   <= 0;
            for (int i = 0; i < LUT_N; i++) m_lut[i] <= 0;
        end else begin
            if (Lut_WrEn) m_lut[Lut_WrAddr] <= int'(Lut_WrData);
            if (Start) begin
                m_state <= S_IDLE;
                m_pc    <= 0;
                m_wrap  <= 0;
                m_cnt   <= 0;
            end else if (m_state == S_IDLE) begin
                m_state <= S_RUN;
            end else if (m_state == S_RUN) begin
                m_cnt <= (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
                if (Ack) begin
                    m_state <= S_HALT;
                end else if (GotoEn) begin
                    m_pc <= m_lut[Target_Idx];
                end else begin
                    m_step = (Jump2En && Zero) ? 2 : 1;
                    if (m_pc + m_step >= PC_SPAN) begin
                        m_wrap <= 1;
                        m_pc   <= m_pc + m_step - PC_SPAN;
                    end else begin
                        m_pc <= m_pc + m_step;
                    end
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge Clk) begin
        if (cmp_en) begin
            check("model_pc",      32'(PC),          32'(m_pc));
            check("model_running", 32'(Running),     32'(m_state == S_RUN));
            check("model_done",    32'(Done),        32'(m_state == S_HALT));
            check("model_wrapped", 32'(Wrapped),     32'(m_wrap));
            check("model_count",   32'(Cycle_Count), 32'(m_cnt));
        end
    end

    task automatic cyc();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic idle_strobes();
        GotoEn = 0; Jump2En = 0; Ack = 0; Zero = 0; Lut_WrEn = 0;
        Target_Idx = '0; Lut_WrAddr = '0; Lut_WrData = '0;
    endtask

    task automatic lut_wr(input int addr, input int data);
        Lut_WrEn = 1; Lut_WrAddr = LUT_AW'(addr); Lut_WrData = PC_W'(data);
        cyc();
        Lut_WrEn = 0;
    endtask

    task automatic goto(input int idx);
        GotoEn = 1; Target_Idx = LUT_AW'(idx);
        cyc();
        GotoEn = 0;
    endtask

    initial begin
        Reset = 1; Start = 1;
        idle_strobes();
        cyc();
        cmp_en = 1'b1;
        cyc();
        check("reset_pc",      32'(PC), 0);
        check("reset_running", 32'(Running), 0);
        check("reset_done",    32'(Done), 0);
        check("reset_wrapped", 32'(Wrapped), 0);
        check("reset_count",   32'(Cycle_Count), 0);

        // Held at program start; load goto targets meanwhile.
        Reset = 0;
        lut_wr(1, 10);
        lut_wr(2, 40);
        lut_wr(3, 1022);
        lut_wr(4, 1023);
        lut_wr(5, 77);
        check("start_pc",      32'(PC), 0);
        check("start_running", 32'(Running), 0);

        Start = 0;
        cyc();
        check("run_entry", 32'(Running), 1);
        check("run_pc0",   32'(PC), 0);
        cyc(); check("inc_pc1", 32'(PC), 1);
        cyc(); check("inc_pc2", 32'(PC), 2);
        cyc(); check("inc_pc3", 32'(PC), 3);
        lut_wr(7, 200);                       // PC 3 -> 4
        cyc(); check("inc_pc5", 32'(PC), 5);
        goto(7);
        check("goto_200",   32'(PC), 200);
        check("goto_count", 32'(Cycle_Count), 6);
        goto(1);
        check("goto_low_pc",   32'(PC), 10);
        check("goto_low_wrap", 32'(Wrapped), 0);
        Jump2En = 1; Zero = 1; cyc();
        check("skip_taken", 32'(PC), 12);
        Zero = 0; cyc();
        check("skip_not_taken", 32'(PC), 13);
        Jump2En = 0;
        goto(2);
        check("goto_40", 32'(PC), 40);
        Ack = 1; GotoEn = 1; Target_Idx = 1; cyc();
        Ack = 0; GotoEn = 0;
        check("halt_pc",      32'(PC), 40);
        check("halt_done",    32'(Done), 1);
        check("halt_running", 32'(Running), 0);
        check("halt_count",   32'(Cycle_Count), 11);
        GotoEn = 1; Target_Idx = 1; cyc(); GotoEn = 0;
        check("halt_frozen_pc",  32'(PC), 40);
        check("halt_frozen_cnt", 32'(Cycle_Count), 11);
        Start = 1; cyc();
        check("restart_pc",    32'(PC), 0);
        check("restart_done",  32'(Done), 0);
        check("restart_count", 32'(Cycle_Count), 0);

        // Wrap by increment.
        Start = 0; cyc();
        goto(3);
        check("wrap_goto", 32'(PC), 1022);
        cyc(); check("wrap_pc1023", 32'(PC), 1023);
        check("wrap_not_yet", 32'(Wrapped), 0);
        cyc(); check("wrap_pc0", 32'(PC), 0);
        check("wrap_set", 32'(Wrapped), 1);
        cyc(); check("wrap_sticky", 32'(Wrapped), 1);

        // Wrap by skip.
        Start = 1; cyc();
        check("wrap_cleared", 32'(Wrapped), 0);
        Start = 0; cyc();
        goto(4);
        Jump2En = 1; Zero = 1; cyc(); Jump2En = 0; Zero = 0;
        check("skip_wrap_pc",  32'(PC), 1);
        check("skip_wrap_set", 32'(Wrapped), 1);

        // Same-cycle write/read returns old entry.
        Lut_WrEn = 1; Lut_WrAddr = 8; Lut_WrData = 500;
        GotoEn = 1; Target_Idx = 8; cyc();
        Lut_WrEn = 0;
        check("lut_old_value", 32'(PC), 0);
        cyc(); GotoEn = 0;
        check("lut_new_value", 32'(PC), 500);

        // Reset mid-run clears everything including the table.
        goto(5);
        check("pre_reset_pc", 32'(PC), 77);
        lut_wr(7, 300);
        Reset = 1; cyc(); Reset = 0;
        check("midreset_pc",      32'(PC), 0);
        check("midreset_running", 32'(Running), 0);
        cyc();
        goto(7);
        check("lut_cleared", 32'(PC), 0);
        check("lut_cleared_run", 32'(Running), 1);

        // Start mid-run aborts and clears Wrapped.
        lut_wr(6, 1023);
        goto(6);
        cyc();
        check("abort_pre_wrap", 32'(Wrapped), 1);
        Start = 1; cyc();
        check("abort_pc",      32'(PC), 0);
        check("abort_wrapped", 32'(Wrapped), 0);
        check("abort_running", 32'(Running), 0);

        // Randomized traffic against the model.
        Start = 0;
        for (int n = 0; n < 3000; n++) begin
            Reset      = ($urandom_range(255) == 0);
            Start      = ($urandom_range(63) == 0);
            Ack        = ($urandom_range(31) == 0);
            GotoEn     = ($urandom_range(7) == 0);
            Jump2En    = ($urandom_range(3) == 0);
            Zero       = 1'($urandom);
            Target_Idx = LUT_AW'($urandom);
            Lut_WrEn   = ($urandom_range(3) == 0);
            Lut_WrAddr = LUT_AW'($urandom);
            Lut_WrData = PC_W'($urandom);
            cyc();
        end

        // Long run without Ack to reach counter saturation.
        Reset = 0; Ack = 0; Start = 1; cyc(); Start = 0;
        for (int n = 0; n < 300; n++) begin
            GotoEn     = ($urandom_range(15) == 0);
            Jump2En    = 1'($urandom);
            Zero       = 1'($urandom);
            Target_Idx = LUT_AW'($urandom);
            Lut_WrEn   = ($urandom_range(7) == 0);
            Lut_WrAddr = LUT_AW'($urandom);
            Lut_WrData = PC_W'($urandom);
            cyc();
        end
        check("count_saturated", 32'(Cycle_Count), CNT_MAX);
        check("sat_running",     32'(Running), 1);

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_instr_fetch
